// File: rtl/io_serial_tx.sv
// Memory-mapped 8N1 serial transmitter: TBR/STR/CTR I/O ports, transmit FIFO and
// a START/DATA/STOP frame FSM whose line output is registered so it cannot glitch.
module io_serial_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'h0040,
    parameter int unsigned DIVISOR    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_switch,
    input  logic [15:0] addr,
    inout  wire  [7:0]  d7_d0,
    input  logic        ior_,
    input  logic        iow_,
    output logic        txd
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned DivW = $clog2(DIVISOR);

    localparam logic [DivW-1:0] DivLast = DivW'(DIVISOR - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;

    logic              iow_q, iow_seen_high_q;
    logic              tx_enable_q, tx_enable_d;
    logic              overrun_q, overrun_d;

    logic              wr_stb, tbr_wr, ctr_wr, push, pop;
    logic              fifo_full, fifo_empty, tx_busy, str_rd;
    logic [7:0]        str;

    // A strobe already low when reset releases is ignored until iow_ has been seen high.
    assign wr_stb = ~iow_ & iow_q & iow_seen_high_q;
    assign tbr_wr = wr_stb && (addr == BASE_ADDR);
    assign ctr_wr = wr_stb && (addr == BASE_ADDR + 16'd2);

    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);
    assign tx_busy    = (state_q != StIdle);

    assign str    = {4'b0000, overrun_q, tx_busy, fifo_empty, fifo_full};
    assign str_rd = ~ior_ && (addr == BASE_ADDR + 16'd1);
    assign d7_d0  = str_rd ? str : 8'bz;

    assign txd = txd_q;

    // Pop is decided first so a write into a full FIFO still lands when a byte leaves.
    assign push = tbr_wr && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        overrun_d   = overrun_q;
        tx_enable_d = tx_enable_q;
        if (tbr_wr && !push) begin
            overrun_d = 1'b1;
        end
        if (ctr_wr) begin
            tx_enable_d = d7_d0[0];
            if (d7_d0[1]) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = 1'b1;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (tx_enable_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                txd_d = 1'b0;
                if (div_q == DivLast) begin
                    div_d   = '0;
                    state_d = StData;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StData: begin
                txd_d = shift_q[0];
                if (div_q == DivLast) begin
                    div_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StStop: begin
                txd_d = 1'b1;
                if (div_q == DivLast) begin
                    div_d   = '0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset_switch) begin
        if (reset_switch) begin
            state_q         <= StIdle;
            div_q           <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            txd_q           <= 1'b1;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            iow_q           <= 1'b1;
            iow_seen_high_q <= 1'b0;
            tx_enable_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            count_q     <= count_d;
            iow_q       <= iow_;
            tx_enable_q <= tx_enable_d;
            overrun_q   <= overrun_d;
            if (iow_) begin
                iow_seen_high_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= d7_d0;
        end
    end

endmodule

// File: tb/tb_io_serial_tx.sv
// Bench for io_serial_tx: register vector table, serial-line receiver with a byte
// scoreboard, and hand sequences for exact frame timing, held strobes and reset abort.
module tb_io_serial_tx;

    localparam logic [15:0] B   = 16'h0040;
    localparam int unsigned Div = 16;

    logic        clock = 1'b0;
    logic        reset_switch;
    logic [15:0] addr;
    wire  [7:0]  d7_d0;
    logic        ior_, iow_;
    logic        txd;
    logic        tb_oe;
    logic [7:0]  tb_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    logic       rx_on = 1'b1;
    logic       rx_busy = 1'b0;

    always #5 clock = ~clock;

    assign d7_d0 = tb_oe ? tb_data : 8'bz;
    // An undriven bus floats to 8'hFF, which STR can never produce.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (d7_d0[i]);
    end

    io_serial_tx #(.BASE_ADDR(B), .DIVISOR(Div), .FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .reset_switch(reset_switch),
        .addr        (addr),
        .d7_d0       (d7_d0),
        .ior_        (ior_),
        .iow_        (iow_),
        .txd         (txd)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int n_low);
        @(negedge clock);
        addr    = a;
        tb_data = d;
        tb_oe   = 1'b1;
        iow_    = 1'b0;
        repeat (n_low) @(negedge clock);
        iow_  = 1'b1;
        tb_oe = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        @(negedge clock);
        addr = a;
        ior_ = 1'b0;
        #1 v = d7_d0;
        ior_ = 1'b1;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((sb.size() != 0 || rx_busy) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check(nm, 32'(t < 3000), 32'd1);
        repeat (20) @(negedge clock);
    endtask

    // Receiver: samples mid-bit, compares each decoded byte with the scoreboard head.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge txd);
            if (rx_on) begin
                rx_busy = 1'b1;
                repeat (Div / 2) @(posedge clock);
                #1 check("rx_start", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (Div) @(posedge clock);
                    #1 b[i] = txd;
                end
                repeat (Div) @(posedge clock);
                #1 check("rx_stop", 32'(txd), 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=%0h required=none", b);
                end else begin
                    check("rx_byte", 32'(b), 32'(sb.pop_front()));
                end
                rx_busy = 1'b0;
            end
        end
    end

    typedef struct {
        logic        is_wr;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic        push;
        logic [15:0] raddr;
        logic [7:0]  exp;
    } vec_t;

    initial begin
        vec_t       vecs [$];
        logic [7:0] v;
        logic [7:0] a5;
        int         wave_err;
        logic       busy_v;
        logic       exp_b;
        int         lows;

        reset_switch = 1'b1;
        addr = '0; ior_ = 1'b1; iow_ = 1'b1; tb_oe = 1'b0; tb_data = '0;
        #1 check("reset_txd", 32'(txd), 32'd1);
        repeat (2) @(negedge clock);
        reset_switch = 1'b0;

        // Transmitter stays disabled, so the FIFO only fills.
        vecs.push_back('{1'b0, 16'h0,     8'h00, 1'b0, B + 16'd1, 8'h02});
        vecs.push_back('{1'b0, 16'h0,     8'h00, 1'b0, B,         8'hFF});
        vecs.push_back('{1'b0, 16'h0,     8'h00, 1'b0, B + 16'd2, 8'hFF});
        vecs.push_back('{1'b0, 16'h0,     8'h00, 1'b0, B + 16'd3, 8'hFF});
        vecs.push_back('{1'b1, B + 16'd3, 8'hFF, 1'b0, B + 16'd1, 8'h02});
        vecs.push_back('{1'b1, B,         8'h11, 1'b1, B + 16'd1, 8'h00});
        vecs.push_back('{1'b1, B,         8'h22, 1'b1, B + 16'd3, 8'hFF});
        vecs.push_back('{1'b1, B,         8'h33, 1'b1, B + 16'd1, 8'h00});
        vecs.push_back('{1'b1, B,         8'h44, 1'b1, B + 16'd1, 8'h01});
        vecs.push_back('{1'b1, B,         8'h55, 1'b0, B + 16'd1, 8'h09});
        vecs.push_back('{1'b1, B + 16'd2, 8'h02, 1'b0, B + 16'd1, 8'h01});
        vecs.push_back('{1'b1, B,         8'h66, 1'b0, B + 16'd1, 8'h09});
        vecs.push_back('{1'b1, B + 16'd4, 8'h00, 1'b0, B + 16'd1, 8'h09});
        vecs.push_back('{1'b1, B + 16'd2, 8'h03, 1'b0, B + 16'd1, 8'h04});

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                if (vecs[i].push) sb.push_back(vecs[i].wdata);
                wr(vecs[i].waddr, vecs[i].wdata, 1);
            end
            rd(vecs[i].raddr, v);
            check($sformatf("vec%0d", i), 32'(v), 32'(vecs[i].exp));
        end
        drain("drain_four");
        rd(B + 16'd1, v);
        check("str_after_four", 32'(v), 32'h02);

        // Exact line waveform for 8'hA5, starting one negedge after the accepting edge.
        a5 = 8'hA5;
        sb.push_back(a5);
        wr(B, a5, 1);
        wave_err = 0;
        busy_v   = 1'b0;
        for (int k = 0; k < 1 + 16 + 128 + 16; k++) begin
            @(negedge clock);
            if (k == 60) begin
                addr = B + 16'd1;
                ior_ = 1'b0;
                #1 busy_v = d7_d0[2];
                ior_ = 1'b1;
            end
            if (k == 0) exp_b = 1'b1;
            else if (k <= 16) exp_b = 1'b0;
            else if (k <= 144) exp_b = a5[(k - 17) / 16];
            else exp_b = 1'b1;
            if (txd !== exp_b) wave_err++;
        end
        check("a5_wave", 32'(wave_err), 32'd0);
        check("a5_busy_mid", 32'(busy_v), 32'd1);
        drain("drain_a5");

        // One strobe held low for 10 cycles queues exactly one byte.
        sb.push_back(8'h3C);
        wr(B, 8'h3C, 10);
        drain("drain_hold");
        rd(B + 16'd1, v);
        check("str_after_hold", 32'(v), 32'h02);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // Abort a frame mid data bit; the second byte is discarded by reset.
        rx_on = 1'b0;
        wr(B, 8'h00, 1);
        wr(B, 8'h77, 1);
        lows = 0;
        while (txd !== 1'b0 && lows < 100) begin
            @(posedge clock);
            lows++;
        end
        check("rst_frame_started", 32'(lows < 100), 32'd1);
        repeat (Div + Div + Div / 2) @(posedge clock);
        #3 check("rst_pre_low", 32'(txd), 32'd0);
        reset_switch = 1'b1;
        #1 check("rst_txd_immediate", 32'(txd), 32'd1);
        @(negedge clock);
        addr    = B;
        tb_data = 8'h99;
        tb_oe   = 1'b1;
        iow_    = 1'b0;
        repeat (3) @(negedge clock);
        reset_switch = 1'b0;
        repeat (5) @(negedge clock);
        tb_oe = 1'b0;
        rd(B + 16'd1, v);
        check("no_accept_after_rst", 32'(v), 32'h02);
        @(negedge clock);
        iow_ = 1'b1;
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        check("no_frame_after_rst", 32'(lows), 32'd0);
        rd(B + 16'd1, v);
        check("str_after_rst", 32'(v), 32'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_serial_tx.md
IO_SERIAL_TX -- requirements
Module: io_serial_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0040, base I/O port of the block's three registers.
REQ-002 SHALL have parameter DIVISOR, default 16, clock cycles per serial bit (range 2..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-004 clock  input  1  system clock; all state changes on rising edge.
REQ-005 reset_switch  input  1  reset, asynchronous, active-high.
REQ-006 addr  input  16  I/O port address from processor.
REQ-007 d7_d0  inout  8  data bus; driven only during a matching status read, high-Z otherwise.
REQ-008 ior_  input  1  I/O read strobe, active-low.
REQ-009 iow_  input  1  I/O write strobe, active-low.
REQ-010 txd  output  1  serial line, idle high.

Function
REQ-011 SHALL decode ports: BASE_ADDR+0 TBR (write-only data), BASE_ADDR+1 STR (read-only status), BASE_ADDR+2 CTR (write-only control); all other ports ignored.
REQ-012 SHALL drive d7_d0 combinationally with STR while ior_=0 and addr=BASE_ADDR+1; reads of any other port, including TBR/CTR, leave d7_d0 high-Z.
REQ-013 STR SHALL be {4'b0, overrun, tx_busy, fifo_empty, fifo_full} (bit0 = fifo_full).
REQ-014 SHALL register iow_ each cycle; a write is accepted exactly once per strobe, on the first rising edge where iow_=0 and the registered previous iow_=1, with addr and d7_d0 sampled at that edge.
REQ-015 TBR write SHALL push d7_d0 into the FIFO; if FIFO full (after any same-cycle pop) the byte SHALL be dropped and overrun set.
REQ-016 CTR write SHALL set tx_enable = d7_d0[0]; d7_d0[1]=1 SHALL clear overrun (clear wins over a same-cycle set); other bits ignored.
REQ-017 Same-cycle pop and push with FIFO full SHALL accept the push (pop evaluated first); occupancy unchanged.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_full when count=FIFO_DEPTH, fifo_empty when count=0.
REQ-019 FSM states IDLE, START, DATA, STOP; frame 8N1, LSB first.
REQ-020 IDLE: txd=1; if tx_enable=1 and FIFO non-empty, pop head into shift register, go START next cycle.
REQ-021 START: txd=0 for DIVISOR cycles -> DATA.
REQ-022 DATA: txd=shift[0] for DIVISOR cycles per bit, shift right, 8 bits -> STOP.
REQ-023 STOP: txd=1 for DIVISOR cycles -> IDLE; back-to-back frames allowed (pop on first IDLE cycle, no extra gap).
REQ-024 tx_busy SHALL be 1 in START, DATA, STOP; 0 in IDLE.
REQ-025 Clearing tx_enable mid-frame SHALL let the current frame finish; no further pops until re-enabled.
REQ-026 Latency: txd falls (start bit) 2 cycles after the accepting write edge when enabled, IDLE and FIFO empty.
REQ-027 Bit counter and divider SHALL be wide enough for DIVISOR and 8 bits without overflow.

Reset
REQ-028 reset_switch=1 SHALL immediately force: state IDLE, txd=1, FIFO emptied (pointers 0), overrun=0, tx_enable=0, divider/bit counter 0, registered iow_=1.
REQ-029 Reset mid-frame SHALL abort the frame with no glitch low on txd; queued bytes discarded.
REQ-030 After reset release, first strobe whose iow_ is already low SHALL NOT be accepted until iow_ returns high and falls again.

Verification
REQ-031 Reset then read BASE+1 -> d7_d0=8'h02; txd=1.
REQ-032 Write CTR=8'h01, TBR=8'hA5 (DIVISOR=16) -> txd low 16 cycles, then bits 1,0,1,0,0,1,0,1 each 16 cycles, stop high 16 cycles; STR bit2=1 during frame.
REQ-033 tx_enable=0, write TBR 5 times (DEPTH=4) -> STR=8'h09 (full, overrun); CTR=8'h03 -> 4 frames sent back-to-back, overrun cleared, STR=8'h02 at end.
REQ-034 Hold iow_ low 10 cycles on TBR -> exactly one byte queued.
REQ-035 Assert reset_switch mid DATA bit -> txd=1 same time step, STR=8'h02 after release, no further frame.
REQ-036 Read BASE+0, BASE+3 and write BASE+3 -> d7_d0 high-Z, no state change.
